// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: sequencing controller for a KxK line-buffer window
// generator. Tracks the raster position of accepted pixels, gates the
// delay-chain shift enable and flags cycles where the window registers
// hold a complete in-image KxK patch.
module conv_window_ctrl #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K     = 3,
  parameter int CW    = 5
) (
  input  logic          iCLK,
  input  logic          iRSTn,
  input  logic          iStart,
  input  logic          iClr,
  input  logic          iValid,
  output logic          oBusy,
  output logic          oShiftEn,
  output logic          oWinValid,
  output logic [CW-1:0] oWinRow,
  output logic [CW-1:0] oWinCol,
  output logic          oFrameDone
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 1);
  localparam logic [CW-1:0] K_M1     = CW'(K - 1);

  state_t        state;
  logic [CW-1:0] row;
  logic [CW-1:0] col;
  logic          accept;
  logic          col_last;
  logic          row_last;
  logic          in_win;

  // A pixel enters the datapath only while running and not being aborted.
  assign accept   = (state == RUN) && iValid && !iClr;
  assign oShiftEn = accept;

  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);
  // The pixel at (row, col) completes a window whose top-left corner is
  // (row-K+1, col-K+1); leading rows/columns hold stale chain data.
  assign in_win   = (row >= K_M1) && (col >= K_M1);

  // Frame sequencing, raster counters and registered window qualifiers.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state      <= IDLE;
      row        <= '0;
      col        <= '0;
      oBusy      <= 1'b0;
      oWinValid  <= 1'b0;
      oWinRow    <= '0;
      oWinCol    <= '0;
      oFrameDone <= 1'b0;
    end else begin
      oWinValid  <= 1'b0;
      oFrameDone <= 1'b0;
      if (iClr) begin
        state <= IDLE;
        row   <= '0;
        col   <= '0;
        oBusy <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (iStart) begin
              state <= RUN;
              row   <= '0;
              col   <= '0;
              oBusy <= 1'b1;
            end
          end
          RUN: begin
            if (iValid) begin
              oWinValid <= in_win;
              if (in_win) begin
                oWinRow <= row - K_M1;
                oWinCol <= col - K_M1;
              end
              if (col_last) begin
                col <= '0;
                if (row_last) begin
                  row        <= '0;
                  state      <= DONE;
                  oFrameDone <= 1'b1;
                end else begin
                  row <= row + 1'b1;
                end
              end else begin
                col <= col + 1'b1;
              end
            end
          end
          DONE: begin
            state <= IDLE;
            oBusy <= 1'b0;
          end
          default: begin
            state <= IDLE;
            oBusy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// tb_conv_window_ctrl: randomized self-checking bench for conv_window_ctrl.
// Instance 0 uses the default 28x28/K=3 frame, instance 1 an 8x6/K=3 frame.
// The reference model derives the raster position of the n-th accepted
// pixel arithmetically and predicts every registered output per cycle.
module tb_conv_window_ctrl;

  localparam int KK = 3;

  logic clk;
  logic rst_n;

  logic v0, s0, c0;
  logic busy0, shift0, wv0, fd0;
  logic [4:0] wrow0, wcol0;

  logic v1, s1, c1;
  logic busy1, shift1, wv1, fd1;
  logic [2:0] wrow1, wcol1;

  conv_window_ctrl #(.IMG_W(28), .IMG_H(28), .K(KK), .CW(5)) dut (
    .iCLK(clk), .iRSTn(rst_n), .iStart(s0), .iClr(c0), .iValid(v0),
    .oBusy(busy0), .oShiftEn(shift0), .oWinValid(wv0),
    .oWinRow(wrow0), .oWinCol(wcol0), .oFrameDone(fd0)
  );

  conv_window_ctrl #(.IMG_W(8), .IMG_H(6), .K(KK), .CW(3)) dut_s (
    .iCLK(clk), .iRSTn(rst_n), .iStart(s1), .iClr(c1), .iValid(v1),
    .oBusy(busy1), .oShiftEn(shift1), .oWinValid(wv1),
    .oWinRow(wrow1), .oWinCol(wcol1), .oFrameDone(fd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state, one slot per instance.
  int pw[2] = '{28, 8};
  int ph[2] = '{28, 6};
  bit m_run[2];
  bit m_done[2];
  int m_n[2];
  int exp_row[2];
  int exp_col[2];
  int wins[2];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_done[i] = 0; m_n[i] = 0;
      exp_row[i] = 0; exp_col[i] = 0; wins[i] = 0;
    end
  endtask

  // One clock cycle of stimulus on instance id, followed by prediction
  // and comparison of every output of that instance.
  task automatic step(input int id, input bit v, input bit st, input bit clr);
    int  g_shift, g_wv, g_fd, g_busy, g_row, g_col;
    int  r, c, w, h;
    bit  acc, e_wv, e_fd;
    w = pw[id]; h = ph[id]; r = 0; c = 0;
    if (id == 0) begin v0 = v; s0 = st; c0 = clr; end
    else         begin v1 = v; s1 = st; c1 = clr; end
    #1;
    g_shift = (id == 0) ? int'(shift0) : int'(shift1);
    acc = m_run[id] && v && !clr;
    check("shift_en", g_shift, int'(acc));
    @(posedge clk); #1;
    e_wv = 0; e_fd = 0;
    if (clr) begin
      m_run[id] = 0; m_done[id] = 0; m_n[id] = 0;
    end else if (acc) begin
      r = m_n[id] / w;
      c = m_n[id] % w;
      if (r >= KK - 1 && c >= KK - 1) begin
        e_wv = 1; exp_row[id] = r - KK + 1; exp_col[id] = c - KK + 1;
      end
      m_n[id]++;
      if (m_n[id] == w * h) begin
        m_run[id] = 0; m_done[id] = 1; e_fd = 1;
      end
    end else if (m_done[id]) begin
      m_done[id] = 0;
    end else if (!m_run[id] && st) begin
      m_run[id] = 1; m_n[id] = 0; wins[id] = 0;
    end
    if (id == 0) begin
      g_wv = int'(wv0); g_fd = int'(fd0); g_busy = int'(busy0);
      g_row = int'(wrow0); g_col = int'(wcol0);
    end else begin
      g_wv = int'(wv1); g_fd = int'(fd1); g_busy = int'(busy1);
      g_row = int'(wrow1); g_col = int'(wcol1);
    end
    check("win_valid", g_wv, int'(e_wv));
    check("frame_done", g_fd, int'(e_fd));
    check("busy", g_busy, int'(m_run[id] || m_done[id]));
    check("win_row", g_row, exp_row[id]);
    check("win_col", g_col, exp_col[id]);
    if (g_wv != 0) begin
      wins[id]++;
      $display("inst%0d window %0d at (%0d,%0d)", id, wins[id], g_row, g_col);
    end
    if (id == 0 && acc) begin
      if (m_n[0] == 58) check("no_win_before_59", wins[0], 0);
      if (m_n[0] == 59) check("first_win_at_59", wins[0], 1);
      if (r == 5 && c < 2) check("row5_nowin", g_wv, 0);
      if (r == 5 && c == 2) begin
        check("row5_c2_row", g_row, 3);
        check("row5_c2_col", g_col, 0);
      end
      if (r == 4 && c == 27) begin
        check("r4c27_row", g_row, 2);
        check("r4c27_col", g_col, 25);
      end
    end
    if (e_fd) begin
      check("win_total", wins[id], (h - KK + 1) * (w - KK + 1));
      $display("inst%0d frame done, %0d windows", id, wins[id]);
    end
  endtask

  // Run the current frame of instance id to completion.
  task automatic run_frame(input int id, input int duty, input int start_pct);
    int guard;
    guard = 0;
    while (!m_done[id] && guard < 8000) begin
      step(id, $urandom_range(0, 99) < duty, $urandom_range(0, 99) < start_pct, 1'b0);
      guard++;
    end
    check("frame_timeout", int'(m_done[id]), 1);
  endtask

  task automatic check_reset_outputs();
    check("rst_busy0", int'(busy0), 0);
    check("rst_wv0", int'(wv0), 0);
    check("rst_fd0", int'(fd0), 0);
    check("rst_row0", int'(wrow0), 0);
    check("rst_col0", int'(wcol0), 0);
    check("rst_shift0", int'(shift0), 0);
    check("rst_busy1", int'(busy1), 0);
    check("rst_wv1", int'(wv1), 0);
  endtask

  initial begin
    v0 = 1; s0 = 0; c0 = 0; v1 = 0; s1 = 0; c1 = 0;
    rst_n = 0;
    model_reset();
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1; rst_n = 1;

    // Idle with iValid held high, plus iClr winning over iStart.
    for (int i = 0; i < 5; i++) step(0, 1'b1, 1'b0, 1'b0);
    step(0, 1'b1, 1'b1, 1'b1);
    step(0, 1'b0, 1'b0, 1'b0);

    // Full frame, continuous iValid.
    step(0, 1'b0, 1'b1, 1'b0);
    run_frame(0, 100, 0);
    step(0, 1'b0, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0, 1'b0);

    // Full frame with ~40% iValid duty.
    step(0, 1'b0, 1'b1, 1'b0);
    run_frame(0, 40, 0);
    step(0, 1'b0, 1'b0, 1'b0);

    // Abort after pixel (10,10), then a clean restart.
    step(0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2000 && m_n[0] < 10 * 28 + 11; i++)
      step(0, $urandom_range(0, 99) < 70, 1'b0, 1'b0);
    step(0, 1'b1, 1'b0, 1'b1);
    step(0, 1'b1, 1'b0, 1'b0);
    step(0, 1'b0, 1'b1, 1'b0);
    run_frame(0, 100, 0);
    step(0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in mid-frame.
    step(0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 50; i++) step(0, 1'b1, 1'b0, 1'b0);
    v0 = 1; rst_n = 0;
    #1;
    model_reset();
    check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1;
    step(0, 1'b1, 1'b0, 1'b0);

    // Small frame with stray iStart pulses during RUN and DONE.
    v0 = 0;
    step(1, 1'b0, 1'b1, 1'b0);
    run_frame(1, 70, 20);
    step(1, 1'b0, 1'b1, 1'b0);
    step(1, 1'b1, 1'b0, 1'b0);
    step(1, 1'b0, 1'b1, 1'b0);
    run_frame(1, 100, 30);
    step(1, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
